// File: rtl/mem_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_copy_engine                                        |
// | Description : Word-granular memory-to-memory copy engine. Reads one  |
// |               word, writes it, and repeats (2 cycles per word) over  |
// |               a single-port data memory with same-cycle reads.       |
// |               Supports abort, alignment checking and pointer wrap.   |
// | Option      : define MEM_COPY_FILL_EN to add a fill mode that writes |
// |               a constant to successive words (1 cycle per word).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_copy_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [8:0]  len,
  input  logic        abort,
`ifdef MEM_COPY_FILL_EN
  input  logic        fill,
  input  logic [31:0] fill_value,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] C_WORD_BYTES = 32'd4;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;
  logic        abt_q, abt_d;
  logic        fill_q, fill_d;
  logic [31:0] fval_q, fval_d;

  // Request-side fill controls; tied off when the fill option is not built.
  logic        w_fill_req;
  logic [31:0] w_fill_val;
`ifdef MEM_COPY_FILL_EN
  assign w_fill_req = fill;
  assign w_fill_val = fill_value;
`else
  assign w_fill_req = 1'b0;
  assign w_fill_val = 32'd0;
`endif

  // A fill never reads, so only the destination must be word aligned then.
  logic w_reject;
  assign w_reject = (dst_addr[1:0] != 2'b00) ||
                    (!w_fill_req && (src_addr[1:0] != 2'b00));

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      cnt_q   <= 9'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      fill_q  <= 1'b0;
      fval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      fill_q  <= fill_d;
      fval_q  <= fval_d;
    end
  end

  // Next-state logic: accept/reject in IDLE, alternate READ/WRITE per word.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    abt_d   = abt_q;
    fill_d  = fill_q;
    fval_d  = fval_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        abt_d = 1'b0;
        if (start) begin
          if (w_reject) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len == 9'd0) begin
            state_d = S_DONE;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            cnt_d   = len;
            fill_d  = w_fill_req;
            fval_d  = w_fill_val;
            state_d = w_fill_req ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        buf_d = mem_read_data;
        if (abort) begin
          // Leave before any write of this word is issued.
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write in this cycle always lands; abort only stops the next word.
        src_d = src_q + C_WORD_BYTES;
        dst_d = dst_q + C_WORD_BYTES;
        cnt_d = cnt_q - 9'd1;
        if (abort) begin
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == 9'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = fill_q ? S_WRITE : S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: memory strobes and status pulses depend on state only.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    aborted        = 1'b0;
    mem_addr       = 32'd0;
    mem_write_data = 32'd0;
    mem_memWrite   = 1'b0;
    mem_memRead    = 1'b0;
    unique case (state_q)
      S_READ: begin
        busy        = 1'b1;
        mem_memRead = 1'b1;
        mem_addr    = src_q;
      end
      S_WRITE: begin
        busy           = 1'b1;
        mem_memWrite   = 1'b1;
        mem_addr       = dst_q;
        mem_write_data = fill_q ? fval_q : buf_q;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        aborted = abt_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_copy_engine                                     |
// | Description : Self-checking bench for mem_copy_engine. A 4 KB word   |
// |               memory model (address bits [11:2]) serves the DUT and  |
// |               a reference copy of memory is updated from the copy    |
// |               rules; timing, pulses and contents are compared.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] dst_addr = 32'd0;
  logic [8:0]  len = 9'd0;
  logic        abort = 1'b0;
  logic        fill = 1'b0;
  logic [31:0] fill_value = 32'd0;
  logic        busy, done, err, aborted;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memWrite, mem_memRead;

  mem_copy_engine u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .abort          (abort),
`ifdef MEM_COPY_FILL_EN
    .fill           (fill),
    .fill_value     (fill_value),
`endif
    .busy           (busy),
    .done           (done),
    .err            (err),
    .aborted        (aborted),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memWrite   (mem_memWrite),
    .mem_memRead    (mem_memRead),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: same-cycle read, write on the rising edge, backdoor preload.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = 10'd0;
  logic [31:0] bd_data = 32'd0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;

  assign mem_read_data = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_memWrite) mem[mem_addr[11:2]] <= mem_write_data;
    if (mem_memWrite) wr_cnt <= wr_cnt + 1;
    if (mem_memRead) rd_cnt <= rd_cnt + 1;
    if (mem_memRead && mem_memWrite) both_cnt <= both_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx[9:0];
    bd_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Reference: copy or fill 'words' words in ascending address order.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int words,
                            input bit f, input logic [31:0] fv);
    logic [31:0] sa, da;
    for (int i = 0; i < words; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      ref_mem[da[11:2]] = f ? fv : ref_mem[sa[11:2]];
    end
  endtask

  // One transfer. amode: 0 none, 1 abort during read #an, 2 abort during write #an.
  task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [8:0] l, input int amode, input int an,
                          input bit f, input logic [31:0] fv, input bit spam,
                          input bit ab_idle);
    bit rej;
    int ecyc, ew, er, eerr, eab;
    int cyc, rdn, wrn, bcnt, w0, r0, g_err, g_ab;
    bit seen;
    rej = (d[1:0] != 2'b00) || (!f && s[1:0] != 2'b00);
    eerr = 0; eab = 0;
    if (rej) begin
      ecyc = 1; ew = 0; er = 0; eerr = 1;
    end else if (l == 9'd0) begin
      ecyc = 1; ew = 0; er = 0;
    end else if (f) begin
      ecyc = int'(l) + 1; ew = int'(l); er = 0;
    end else if (amode == 1 && an >= 1 && an <= int'(l)) begin
      ecyc = 2 * an; ew = an - 1; er = an; eab = 1;
    end else if (amode == 2 && an >= 1 && an <= int'(l)) begin
      ecyc = 2 * an + 1; ew = an; er = an; eab = 1;
    end else begin
      ecyc = 2 * int'(l) + 1; ew = int'(l); er = int'(l);
    end

    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; fill = f; fill_value = fv;
    start = 1'b1; abort = ab_idle;
    w0 = wr_cnt; r0 = rd_cnt;
    @(posedge clk);
    cyc = 0; rdn = 0; wrn = 0; bcnt = 0; seen = 1'b0; g_err = 0; g_ab = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = spam && (cyc == 2);
      if (spam && cyc == 2) src_addr = s ^ 32'h0000_0100;
      if (mem_memRead) rdn++;
      if (mem_memWrite) wrn++;
      abort = (amode == 1 && mem_memRead && rdn == an) ||
              (amode == 2 && mem_memWrite && wrn == an);
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1; g_err = int'(err); g_ab = int'(aborted);
        abort = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc, ecyc);
    check({tag, "_busy_cycles"}, bcnt, ecyc - 1);
    check({tag, "_err"}, g_err, eerr);
    check({tag, "_aborted"}, g_ab, eab);
    @(negedge clk);
    abort = 1'b0;
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_writes"}, wr_cnt - w0, ew);
    check({tag, "_reads"}, rd_cnt - r0, er);
    model_copy(s, d, ew, f, fv);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [31:0] s, d;
    logic [8:0]  l;
    int          am, an, w0, cyc, wrn, dcnt;
    bit          hit;

    // Preload memory with random data while the DUT is held in reset.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = i[9:0]; bd_data = $urandom; ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    check("reset_ctl", {26'd0, busy, done, err, aborted, mem_memRead, mem_memWrite}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_write_data, 32'd0);
    rst_n = 1'b1;

    // Directed copy of four known words.
    bd_write(0, 32'h11); bd_write(1, 32'h22); bd_write(2, 32'h33); bd_write(3, 32'h44);
    run_xfer("copy4", 32'h0, 32'h40, 9'd4, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("copy4_word3", mem[19], 32'h44);

    run_xfer("len0", 32'h10, 32'h20, 9'd0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("misalign_dst", 32'h0, 32'h42, 9'd4, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("misalign_src", 32'h1, 32'h80, 9'd2, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("abort_rd3", 32'h100, 32'h200, 9'd8, 1, 3, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("restart", 32'h100, 32'h300, 9'd2, 0, 0, 1'b0, 32'd0, 1'b0, 1'b1);
    run_xfer("abort_wr2", 32'h140, 32'h240, 9'd5, 2, 2, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("start_busy", 32'h180, 32'h380, 9'd3, 0, 0, 1'b0, 32'd0, 1'b1, 1'b0);
    run_xfer("wrap", 32'hFFFF_FFF8, 32'h400, 9'd4, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("overlap", 32'h500, 32'h504, 9'd6, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_xfer("len256", 32'h000, 32'h800, 9'd256, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Reset asserted during the second write of a 4-word copy.
    @(negedge clk);
    src_addr = 32'h600; dst_addr = 32'h700; len = 9'd4; start = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    cyc = 0; wrn = 0; dcnt = 0; hit = 1'b0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      start = 1'b0; cyc++;
      if (done) dcnt++;
      if (mem_memWrite) begin
        wrn++;
        if (wrn == 2) begin rst_n = 1'b0; hit = 1'b1; end
      end
    end
    check("rstmid_reached", 32'(hit), 32'd1);
    @(negedge clk);
    check("rstmid_ctl", {26'd0, busy, done, err, aborted, mem_memRead, mem_memWrite}, 32'd0);
    check("rstmid_addr", mem_addr, 32'd0);
    check("rstmid_wdata", mem_write_data, 32'd0);
    check("rstmid_no_done", dcnt, 0);
    check("rstmid_writes", wr_cnt - w0, 2);
    rst_n = 1'b1;
    model_copy(32'h600, 32'h700, 2, 1'b0, 32'd0);
    check_mem("rstmid_mem");

`ifdef MEM_COPY_FILL_EN
    run_xfer("fill3", 32'h3, 32'h80, 9'd3, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("fill3_word0", mem[32], 32'hDEAD_BEEF);
`endif

    // Randomized transfers against the reference model.
    for (int t = 0; t < 25; t++) begin
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
      l  = 9'($urandom_range(0, 40));
      am = $urandom_range(0, 2);
      an = $urandom_range(1, 41);
`ifdef MEM_COPY_FILL_EN
      if ($urandom_range(0, 3) == 0)
        run_xfer("rand_fill", s, d, l, 0, 0, 1'b1, $urandom, 1'b0, 1'b0);
      else
`endif
      run_xfer("rand", s, d, l, am, an, 1'b0, 32'd0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    check("rd_wr_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
